// File: rtl/spi_xfer_sched_pkg.sv
// spi_xfer_sched_pkg: SFR map, FSM encoding and fixed register values
// shared by the SPI transfer scheduler.
package spi_xfer_sched_pkg;

    localparam logic [2:0] ADDR_CR1 = 3'd0;
    localparam logic [2:0] ADDR_CR2 = 3'd1;
    localparam logic [2:0] ADDR_BR  = 3'd2;
    localparam logic [2:0] ADDR_DR1 = 3'd3;
    localparam logic [2:0] ADDR_SR  = 3'd3;
    localparam logic [2:0] ADDR_DR2 = 3'd5;

    localparam logic [7:0] CR1_MASTER = 8'h10;
    localparam logic [7:0] CR2_INIT   = 8'h01;
    localparam logic [7:0] SSN_IDLE   = 8'hFF;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_ARB,
        S_WR_CR1,
        S_WR_BR,
        S_WR_DR,
        S_WAIT_LO,
        S_WAIT_HI,
        S_RD,
        S_ABORT,
        S_FIN
    } state_e;

endpackage

// File: rtl/spi_xfer_sched_if.sv
// spi_xfer_sched_if: requester bundle plus the SPI SFR port, bundled
// so the scheduler (master) and its environment (slave) share one port.
interface spi_xfer_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][7:0]  req_cr1;
    logic [NREQ-1:0][7:0]  req_br;
    logic [NREQ-1:0][7:0]  req_ssn;
    logic [NREQ-1:0][7:0]  req_txd;
    logic [NREQ-1:0]       done;
    logic                  err;
    logic [7:0]            rxd;
    logic                  busy;
    logic                  sfrwe;
    logic [2:0]            sfraddr_w;
    logic [2:0]            sfraddr_r;
    logic [7:0]            spidata_o;
    logic [7:0]            sfrdatai;
    logic [7:0]            spssn_o;

    modport master (
        input  req, req_cr1, req_br, req_ssn, req_txd, sfrdatai,
        output done, err, rxd, busy,
        output sfrwe, sfraddr_w, sfraddr_r, spidata_o, spssn_o
    );

    modport slave (
        output req, req_cr1, req_br, req_ssn, req_txd, sfrdatai,
        input  done, err, rxd, busy,
        input  sfrwe, sfraddr_w, sfraddr_r, spidata_o, spssn_o
    );
endinterface

// File: rtl/spi_xfer_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or
// after ptr_i, wrapping; returns one-hot grant and binary index.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]                         req_i,
    input  logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] ptr_i,
    output logic [NREQ-1:0]                         gnt_o,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] idx_o,
    output logic                                    valid_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] rot;
    logic [IW:0]     pos;

    // Rotate so bit k is requester (ptr+k) mod NREQ; lowest k wins.
    always_comb begin
        rot     = NREQ'({req_i, req_i} >> ptr_i);
        pos     = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        gnt_o   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pos = {1'b0, ptr_i} + (IW + 1)'(k);
                if (pos >= (IW + 1)'(NREQ)) begin
                    pos = pos - (IW + 1)'(NREQ);
                end
                idx_o   = pos[IW-1:0];
                valid_o = 1'b1;
            end
        end
        for (int k = 0; k < NREQ; k++) begin
            gnt_o[k] = valid_o && (idx_o == IW'(k));
        end
    end
endmodule

// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: round-robin owner of one SPI controller's SFR port;
// programs CR1/BR/DR1 per grant, polls SPISR[0], returns SPIDR2.
module spi_xfer_sched
    import spi_xfer_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input logic              clk,
    input logic              rst_n,
    spi_xfer_sched_if.master bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we_q, we_d;
    logic [2:0]      waddr_q, waddr_d;
    logic [2:0]      raddr_q, raddr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      ssn_q, ssn_d;
    logic [7:0]      rxd_q, rxd_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_q, err_d;
    logic            busy_q, busy_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_valid;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i   (bus.req),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            idx_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
            ssn_q   <= SSN_IDLE;
            rxd_q   <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            wdata_q <= wdata_d;
            ssn_q   <= ssn_d;
            rxd_q   <= rxd_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // Bus outputs are registered: each state's write lands the next cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        wdata_d = wdata_q;
        ssn_d   = ssn_q;
        rxd_d   = rxd_q;
        done_d  = '0;
        err_d   = err_q;
        busy_d  = busy_q;
        unique case (state_q)
            S_INIT: begin
                we_d    = 1'b1;
                waddr_d = ADDR_CR2;
                wdata_d = CR2_INIT;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                busy_d = 1'b0;
                if (|bus.req) state_d = S_ARB;
            end
            S_ARB: begin
                if (arb_valid) begin
                    idx_d   = arb_idx;
                    gnt_d   = arb_gnt;
                    busy_d  = 1'b1;
                    ssn_d   = bus.req_ssn[arb_idx];
                    state_d = S_WR_CR1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WR_CR1: begin
                we_d    = 1'b1;
                waddr_d = ADDR_CR1;
                wdata_d = bus.req_cr1[idx_q] | CR1_MASTER;
                state_d = S_WR_BR;
            end
            S_WR_BR: begin
                we_d    = 1'b1;
                waddr_d = ADDR_BR;
                wdata_d = bus.req_br[idx_q];
                state_d = S_WR_DR;
            end
            S_WR_DR: begin
                we_d    = 1'b1;
                waddr_d = ADDR_DR1;
                wdata_d = bus.req_txd[idx_q];
                raddr_d = ADDR_SR;
                cnt_d   = '0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) state_d = S_ABORT;
                else if (!bus.sfrdatai[0]) state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = S_ABORT;
                end else if (bus.sfrdatai[0]) begin
                    raddr_d = ADDR_DR2;
                    state_d = S_RD;
                end
            end
            S_RD: begin
                rxd_d   = bus.sfrdatai;
                done_d  = gnt_q;
                err_d   = 1'b0;
                state_d = S_FIN;
            end
            S_ABORT: begin
                we_d    = 1'b1;
                waddr_d = ADDR_CR1;
                wdata_d = 8'h00;
                rxd_d   = 8'h00;
                done_d  = gnt_q;
                err_d   = 1'b1;
                state_d = S_FIN;
            end
            S_FIN: begin
                ssn_d   = SSN_IDLE;
                busy_d  = 1'b0;
                ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    assign bus.sfrwe     = we_q;
    assign bus.sfraddr_w = waddr_q;
    assign bus.sfraddr_r = raddr_q;
    assign bus.spidata_o = wdata_q;
    assign bus.spssn_o   = ssn_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rxd       = rxd_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb_spi_xfer_sched: scoreboard bench for the SPI transfer scheduler with
// a small SPI SFR model (SPISR low for lo_len cycles, SPIDR2 = ~txd).
module tb_spi_xfer_sched;
    localparam int NREQ = 4;
    localparam int TMO  = 64;

    typedef struct {
        logic [2:0] a;
        logic [7:0] d;
        int         cyc;
    } wr_t;

    typedef struct {
        logic [NREQ-1:0] done;
        logic            err;
        logic [7:0]      rxd;
        logic [7:0]      ssn;
        int              cyc;
    } dn_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_xfer_sched_if #(.NREQ(NREQ)) bus ();

    spi_xfer_sched #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;
    int multi_done = 0;
    int cyc = 0;

    logic [7:0] c_cr1 [NREQ];
    logic [7:0] c_br  [NREQ];
    logic [7:0] c_ssn [NREQ];
    logic [7:0] c_txd [NREQ];

    wr_t wr_obs[$];
    wr_t wr_exp[$];
    dn_t dn_obs[$];
    dn_t dn_exp[$];

    // SPI model: DR1 write starts a transfer; SPIDR2 returns ~txd.
    int unsigned lo_len = 2;
    int unsigned lowcnt = 0;
    logic        stuck_hi = 1'b0;
    logic [7:0]  dr2_q = 8'h00;
    logic        spif;

    always @(posedge clk) begin
        if (bus.sfrwe && bus.sfraddr_w == 3'd3) begin
            lowcnt <= lo_len;
            dr2_q  <= ~bus.spidata_o;
        end else if (lowcnt != 0) begin
            lowcnt <= lowcnt - 1;
        end
    end

    assign spif = stuck_hi || (lowcnt == 0);
    assign bus.sfrdatai = (bus.sfraddr_r == 3'd3) ? {7'd0, spif} :
                          (bus.sfraddr_r == 3'd5) ? dr2_q : 8'h00;

    always @(negedge clk) begin : mon
        wr_t w;
        dn_t d;
        cyc++;
        if (rst_n) begin
            if (bus.sfrwe) begin
                w.a = bus.sfraddr_w;
                w.d = bus.spidata_o;
                w.cyc = cyc;
                wr_obs.push_back(w);
            end
            if (|bus.done) begin
                d.done = bus.done;
                d.err = bus.err;
                d.rxd = bus.rxd;
                d.ssn = bus.spssn_o;
                d.cyc = cyc;
                dn_obs.push_back(d);
                if (!$onehot(bus.done)) multi_done++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cfg(input int k, input logic [7:0] cr1,
                           input logic [7:0] br, input logic [7:0] ssn,
                           input logic [7:0] txd);
        c_cr1[k] = cr1;
        c_br[k]  = br;
        c_ssn[k] = ssn;
        c_txd[k] = txd;
        bus.req_cr1[k] = cr1;
        bus.req_br[k]  = br;
        bus.req_ssn[k] = ssn;
        bus.req_txd[k] = txd;
    endtask

    task automatic push_wr(input logic [2:0] a, input logic [7:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        w.cyc = 0;
        wr_exp.push_back(w);
    endtask

    task automatic push_xfer(input int k, input logic err);
        dn_t d;
        push_wr(3'd0, c_cr1[k] | 8'h10);
        push_wr(3'd2, c_br[k]);
        push_wr(3'd3, c_txd[k]);
        if (err) push_wr(3'd0, 8'h00);
        d.done = NREQ'(1) << k;
        d.err  = err;
        d.rxd  = err ? 8'h00 : ~c_txd[k];
        d.ssn  = c_ssn[k];
        d.cyc  = 0;
        dn_exp.push_back(d);
    endtask

    task automatic wait_dones(input int n, input int budget, output bit ok);
        int k = 0;
        while (dn_obs.size() < n && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        ok = (dn_obs.size() >= n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req = '0;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        wr_obs.delete();
        dn_obs.delete();
        wr_exp.delete();
        dn_exp.delete();
    endtask

    task automatic test_reset();
        wr_t o;
        rst_n = 1'b0;
        bus.req = '0;
        tick(3);
        checks++;
        if (bus.spssn_o !== 8'hFF) $display("FAIL rst_ssn: got %h need ff", bus.spssn_o);
        else passed++;
        checks++;
        if (bus.done !== '0 || bus.busy !== 1'b0)
            $display("FAIL rst_done_busy: got done=%b busy=%b need 0", bus.done, bus.busy);
        else passed++;
        checks++;
        if (bus.sfrwe !== 1'b0 || bus.err !== 1'b0 || bus.rxd !== 8'h00)
            $display("FAIL rst_regs: got we=%b err=%b rxd=%h need 0", bus.sfrwe, bus.err, bus.rxd);
        else passed++;
        rst_n = 1'b1;
        tick(5);
        checks++;
        if (wr_obs.size() != 1) $display("FAIL init_count: got %0d writes need 1", wr_obs.size());
        else passed++;
        if (wr_obs.size() > 0) begin
            o = wr_obs.pop_front();
            checks++;
            if (o.a !== 3'd1 || o.d !== 8'h01)
                $display("FAIL init_write: got (%0d,%h) need (1,01)", o.a, o.d);
            else passed++;
        end
        checks++;
        if (dn_obs.size() != 0 || bus.spssn_o !== 8'hFF)
            $display("FAIL idle: got %0d dones ssn=%h need 0 ff", dn_obs.size(), bus.spssn_o);
        else passed++;
        wr_obs.delete();
        dn_obs.delete();
    endtask

    task automatic test_single();
        wr_t e, o;
        dn_t de, dob;
        bit ok;
        int dr_cyc = 0;
        set_cfg(0, 8'h40, 8'h03, 8'hFE, 8'hA5);
        push_xfer(0, 1'b0);
        bus.req[0] = 1'b1;
        tick(3);
        checks++;
        if (bus.busy !== 1'b1) $display("FAIL single_busy: got %b need 1", bus.busy);
        else passed++;
        wait_dones(1, 50, ok);
        bus.req[0] = 1'b0;
        checks++;
        if (!ok) $display("FAIL single_wait: got %0d dones need 1", dn_obs.size());
        else passed++;
        tick(3);
        while (wr_exp.size() > 0) begin
            e = wr_exp.pop_front();
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            else begin o.a = 'x; o.d = 'x; o.cyc = -1; end
            if (o.a === 3'd3) dr_cyc = o.cyc;
            checks++;
            if (o.a !== e.a || o.d !== e.d)
                $display("FAIL single_wr: got (%0d,%h) need (%0d,%h)", o.a, o.d, e.a, e.d);
            else passed++;
        end
        while (dn_exp.size() > 0 && dn_obs.size() > 0) begin
            de = dn_exp.pop_front();
            dob = dn_obs.pop_front();
            checks++;
            if (dob.done !== de.done || dob.err !== de.err || dob.rxd !== de.rxd || dob.ssn !== de.ssn)
                $display("FAIL single_done: got %b/%b/%h/%h need %b/%b/%h/%h", dob.done, dob.err,
                         dob.rxd, dob.ssn, de.done, de.err, de.rxd, de.ssn);
            else passed++;
            checks++;
            if (dob.cyc - dr_cyc != 5)
                $display("FAIL single_latency: got %0d need 5", dob.cyc - dr_cyc);
            else passed++;
        end
        checks++;
        if (wr_obs.size() != 0 || dn_obs.size() != 0 || bus.busy !== 1'b0)
            $display("FAIL single_extra: got %0d wr %0d dn busy=%b need 0", wr_obs.size(),
                     dn_obs.size(), bus.busy);
        else passed++;
        dn_exp.delete();
    endtask

    task automatic test_round_robin();
        wr_t e, o;
        dn_t de, dob;
        bit ok;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_cfg(i, 8'h01 << i, 8'(i + 1), ~(8'h01 << i), 8'(8'h30 + i));
        end
        for (int n = 0; n < 5; n++) push_xfer(n % NREQ, 1'b0);
        bus.req = '1;
        wait_dones(5, 200, ok);
        bus.req = '0;
        checks++;
        if (!ok) $display("FAIL rr_wait: got %0d dones need 5", dn_obs.size());
        else passed++;
        tick(4);
        while (wr_exp.size() > 0) begin
            e = wr_exp.pop_front();
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            else begin o.a = 'x; o.d = 'x; o.cyc = -1; end
            checks++;
            if (o.a !== e.a || o.d !== e.d)
                $display("FAIL rr_wr: got (%0d,%h) need (%0d,%h)", o.a, o.d, e.a, e.d);
            else passed++;
        end
        while (dn_exp.size() > 0 && dn_obs.size() > 0) begin
            de = dn_exp.pop_front();
            dob = dn_obs.pop_front();
            checks++;
            if (dob.done !== de.done || dob.err !== de.err || dob.rxd !== de.rxd || dob.ssn !== de.ssn)
                $display("FAIL rr_done: got %b/%b/%h/%h need %b/%b/%h/%h", dob.done, dob.err,
                         dob.rxd, dob.ssn, de.done, de.err, de.rxd, de.ssn);
            else passed++;
        end
        checks++;
        if (multi_done != 0) $display("FAIL rr_onehot: got %0d multi-bit dones need 0", multi_done);
        else passed++;
        dn_exp.delete();
        dn_obs.delete();
        wr_obs.delete();
    endtask

    task automatic test_timeout();
        wr_t e, o;
        dn_t de, dob;
        bit ok;
        int dr_cyc = 0;
        int ab_cyc = 0;
        set_cfg(1, 8'h02, 8'h07, 8'hFD, 8'h3C);
        push_xfer(1, 1'b1);
        stuck_hi = 1'b1;
        bus.req[1] = 1'b1;
        wait_dones(1, TMO + 50, ok);
        bus.req[1] = 1'b0;
        stuck_hi = 1'b0;
        checks++;
        if (!ok) $display("FAIL tmo_wait: got %0d dones need 1", dn_obs.size());
        else passed++;
        tick(2);
        while (wr_exp.size() > 0) begin
            e = wr_exp.pop_front();
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            else begin o.a = 'x; o.d = 'x; o.cyc = -1; end
            if (e.a == 3'd3) dr_cyc = o.cyc;
            if (e.a == 3'd0 && e.d == 8'h00) ab_cyc = o.cyc;
            checks++;
            if (o.a !== e.a || o.d !== e.d)
                $display("FAIL tmo_wr: got (%0d,%h) need (%0d,%h)", o.a, o.d, e.a, e.d);
            else passed++;
        end
        checks++;
        if (ab_cyc - dr_cyc != TMO + 1)
            $display("FAIL tmo_dwell: got %0d need %0d", ab_cyc - dr_cyc, TMO + 1);
        else passed++;
        if (dn_exp.size() > 0 && dn_obs.size() > 0) begin
            de = dn_exp.pop_front();
            dob = dn_obs.pop_front();
            checks++;
            if (dob.done !== de.done || dob.err !== de.err || dob.rxd !== de.rxd || dob.cyc != ab_cyc)
                $display("FAIL tmo_done: got %b/%b/%h@%0d need %b/%b/%h@%0d", dob.done, dob.err,
                         dob.rxd, dob.cyc, de.done, de.err, de.rxd, ab_cyc);
            else passed++;
        end
        set_cfg(2, 8'h04, 8'h01, 8'hFB, 8'h77);
        push_xfer(2, 1'b0);
        bus.req[2] = 1'b1;
        wait_dones(1, 50, ok);
        bus.req[2] = 1'b0;
        tick(2);
        while (wr_exp.size() > 0) begin
            e = wr_exp.pop_front();
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            else begin o.a = 'x; o.d = 'x; o.cyc = -1; end
            checks++;
            if (o.a !== e.a || o.d !== e.d)
                $display("FAIL tmo_next_wr: got (%0d,%h) need (%0d,%h)", o.a, o.d, e.a, e.d);
            else passed++;
        end
        de = dn_exp.pop_front();
        checks++;
        if (dn_obs.size() == 0) begin
            $display("FAIL tmo_next_done: got none need %b", de.done);
        end else begin
            dob = dn_obs.pop_front();
            if (dob.done !== de.done || dob.err !== de.err || dob.rxd !== de.rxd)
                $display("FAIL tmo_next_done: got %b/%b/%h need %b/%b/%h", dob.done, dob.err,
                         dob.rxd, de.done, de.err, de.rxd);
            else passed++;
        end
        wr_obs.delete();
        dn_obs.delete();
    endtask

    task automatic test_reset_mid();
        wr_t e, o;
        int k = 0;
        set_cfg(3, 8'h08, 8'h02, 8'hF7, 8'h5C);
        push_wr(3'd0, 8'h18);
        push_wr(3'd2, 8'h02);
        push_wr(3'd3, 8'h5C);
        push_wr(3'd1, 8'h01);
        lo_len = 20;
        bus.req[3] = 1'b1;
        while (wr_obs.size() < 3 && k < 30) begin
            @(negedge clk);
            #1;
            k++;
        end
        tick(3);
        rst_n = 1'b0;
        tick(1);
        checks++;
        if (bus.spssn_o !== 8'hFF || bus.busy !== 1'b0 || bus.done !== '0)
            $display("FAIL mid_rst: got ssn=%h busy=%b done=%b need ff 0 0", bus.spssn_o,
                     bus.busy, bus.done);
        else passed++;
        bus.req = '0;
        rst_n = 1'b1;
        lo_len = 2;
        tick(30);
        while (wr_exp.size() > 0) begin
            e = wr_exp.pop_front();
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            else begin o.a = 'x; o.d = 'x; o.cyc = -1; end
            checks++;
            if (o.a !== e.a || o.d !== e.d)
                $display("FAIL mid_wr: got (%0d,%h) need (%0d,%h)", o.a, o.d, e.a, e.d);
            else passed++;
        end
        checks++;
        if (dn_obs.size() != 0 || wr_obs.size() != 0)
            $display("FAIL mid_silent: got %0d dones %0d writes need 0", dn_obs.size(), wr_obs.size());
        else passed++;
        wr_obs.delete();
        dn_obs.delete();
    endtask

    task automatic test_req_drop();
        wr_t e, o;
        dn_t de, dob;
        bit ok;
        int k = 0;
        set_cfg(2, 8'h20, 8'h05, 8'hFB, 8'hC3);
        set_cfg(0, 8'h00, 8'h09, 8'hFE, 8'h11);
        set_cfg(3, 8'h80, 8'h0A, 8'hF7, 8'h99);
        push_xfer(2, 1'b0);
        bus.req = 4'b0100;
        while (bus.busy !== 1'b1 && k < 10) begin
            @(negedge clk);
            k++;
        end
        bus.req = '0;
        wait_dones(1, 50, ok);
        checks++;
        if (!ok) $display("FAIL drop_wait: got %0d dones need 1", dn_obs.size());
        else passed++;
        tick(2);
        push_xfer(3, 1'b0);
        push_xfer(0, 1'b0);
        bus.req = 4'b1001;
        wait_dones(3, 100, ok);
        bus.req = '0;
        tick(3);
        while (wr_exp.size() > 0) begin
            e = wr_exp.pop_front();
            if (wr_obs.size() > 0) o = wr_obs.pop_front();
            else begin o.a = 'x; o.d = 'x; o.cyc = -1; end
            checks++;
            if (o.a !== e.a || o.d !== e.d)
                $display("FAIL drop_wr: got (%0d,%h) need (%0d,%h)", o.a, o.d, e.a, e.d);
            else passed++;
        end
        while (dn_exp.size() > 0) begin
            de = dn_exp.pop_front();
            checks++;
            if (dn_obs.size() == 0) begin
                $display("FAIL drop_done: got none need %b", de.done);
            end else begin
                dob = dn_obs.pop_front();
                if (dob.done !== de.done || dob.err !== de.err || dob.rxd !== de.rxd || dob.ssn !== de.ssn)
                    $display("FAIL drop_done: got %b/%b/%h/%h need %b/%b/%h/%h", dob.done, dob.err,
                             dob.rxd, dob.ssn, de.done, de.err, de.rxd, de.ssn);
                else passed++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = '0;
        for (int i = 0; i < NREQ; i++) set_cfg(i, 8'h00, 8'h00, 8'hFF, 8'h00);
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_req_drop();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish need finish by 500000");
        $fatal(1, "watchdog");
    end
endmodule
